banco_regs_p: RTL and testbench

//  Parametrised register bank for the datapath: DEPTH words of WIDTH bits, NUM_RD

---
 rtl/banco_pkg.sv | 18 +
 rtl/banco_clr_fsm.sv | 54 +++++
 rtl/banco_regs_p.sv | 76 +++++++
 tb/tb_banco_regs_p.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banco_pkg.sv
// Shared types and defaults for the banco_regs_p register bank.
// Holds the clear-engine state type and a constant log2 helper.
package banco_pkg;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} clr_state_t;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/banco_clr_fsm.sv
// Bulk-clear sequencer: walks an address counter over every register, one per clock,
// and flags busy for exactly DEPTH cycles.
module banco_clr_fsm
  import banco_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW_W  = clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  output logic            o_busy,
  output logic            o_clr_we,
  output logic [AW_W-1:0] o_clr_addr
);

  clr_state_t      r_state;
  clr_state_t      w_state_nxt;
  logic [AW_W-1:0] r_cnt;
  logic [AW_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A clr seen while already clearing is ignored; the sweep always runs to the end.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (i_clr) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == AW_W'(DEPTH - 1)) w_state_nxt = IDLE;
      end
    endcase
  end

  assign o_busy     = (r_state == CLEAR);
  assign o_clr_we   = o_busy;
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/banco_regs_p.sv
// Register bank: DEPTH x WIDTH storage, NUM_RD combinational read ports, one write port,
// sequenced bulk clear. Define BANCO_BYPASS_EN to forward same-cycle write data to reads.
module banco_regs_p
  import banco_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int ZERO_R0 = 1,
  localparam int AW_W   = clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*AW_W-1:0]   AR,
  input  logic [AW_W-1:0]          AW,
  input  logic                     en,
  input  logic [WIDTH-1:0]         DW,
  input  logic                     clr,
  output logic [NUM_RD*WIDTH-1:0]  DR,
  output logic                     busy
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] w_rd  [NUM_RD];
  logic             w_busy;
  logic             w_clr_we;
  logic [AW_W-1:0]  w_clr_addr;
  logic             w_wr_ok;

  banco_clr_fsm #(
    .DEPTH (DEPTH),
    .AW_W  (AW_W)
  ) u_clr_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (clr),
    .o_busy     (w_busy),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign busy    = w_busy;
  assign w_wr_ok = en && !w_busy && !((ZERO_R0 != 0) && (AW == '0));

  // Clear engine owns the write port while busy; writeback requests are dropped then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_ok) begin
      r_mem[AW] <= DW;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW_W-1:0] w_ra;
    logic            w_zero;
    logic            w_fwd;

    assign w_ra   = AR[k*AW_W +: AW_W];
    assign w_zero = (ZERO_R0 != 0) && (w_ra == '0);
`ifdef BANCO_BYPASS_EN
    assign w_fwd  = w_wr_ok && (AW == w_ra);
`else
    assign w_fwd  = 1'b0;
`endif
    assign w_rd[k] = w_zero ? '0 : (w_fwd ? DW : r_mem[w_ra]);
  end

  always_comb begin
    DR = '0;
    for (int k = 0; k < NUM_RD; k++) DR[k*WIDTH +: WIDTH] = w_rd[k];
  end

endmodule

// File: tb/tb_banco_regs_p.sv
// Randomised self-checking bench for banco_regs_p against an array-based reference model.
module tb_banco_regs_p;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 32 x 32, two ports, hardwired R0
  logic [9:0]   ar_a = '0;
  logic [4:0]   aw_a = '0;
  logic         en_a = 1'b0;
  logic [31:0]  dw_a = '0;
  logic         clr_a = 1'b0;
  logic [63:0]  dr_a;
  logic         busy_a;

  // Instance B: 16 x 32, four ports, ordinary R0
  logic [15:0]  ar_b = '0;
  logic [3:0]   aw_b = '0;
  logic         en_b = 1'b0;
  logic [31:0]  dw_b = '0;
  logic         clr_b = 1'b0;
  logic [127:0] dr_b;
  logic         busy_b;

  banco_regs_p #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .ZERO_R0(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .AR(ar_a), .AW(aw_a), .en(en_a), .DW(dw_a),
    .clr(clr_a), .DR(dr_a), .busy(busy_a)
  );

  banco_regs_p #(.WIDTH(32), .DEPTH(16), .NUM_RD(4), .ZERO_R0(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .AR(ar_b), .AW(aw_b), .en(en_b), .DW(dw_b),
    .clr(clr_b), .DR(dr_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_a [32];
  int          left_a;
  logic [31:0] m_b [16];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_a[i] = '0;
    for (int i = 0; i < 16; i++) m_b[i] = '0;
    left_a = 0;
  endtask

  // Advance one clock and apply the architectural rules to the models.
  task automatic tick();
    @(posedge clk);
    if (left_a > 0) begin
      m_a[32 - left_a] = '0;
      left_a--;
    end else begin
      if (en_a && aw_a != 5'd0) m_a[aw_a] = dw_a;
      if (clr_a) left_a = 32;
    end
    if (en_b) m_b[aw_b] = dw_b;
    #1;
  endtask

  function automatic logic [31:0] exp_a(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef BANCO_BYPASS_EN
    if (en_a && left_a == 0 && aw_a == a) return dw_a;
`endif
    return m_a[a];
  endfunction

  function automatic logic [31:0] exp_b(input logic [3:0] a);
`ifdef BANCO_BYPASS_EN
    if (en_b && aw_b == a) return dw_b;
`endif
    return m_b[a];
  endfunction

  task automatic test_reset();
    logic [31:0] got;
    rst_n = 1'b0;
    model_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      total++;
      got = dr_a[k*32 +: 32];
      if (got !== 32'd0) begin
        bad++;
        $display("FAIL reset_dr%0d: got %h want %h", k, got, 32'd0);
      end
    end
    total++;
    if (busy_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b want 0", busy_a);
    end
    rst_n = 1'b1;
    tick();
    en_a = 1'b1; aw_a = 5'd5; dw_a = 32'hDEAD_BEEF;
    tick();
    en_a = 1'b0; ar_a[4:0] = 5'd5;
    #1;
    total++;
    if (dr_a[31:0] !== exp_a(5'd5)) begin
      bad++;
      $display("FAIL reset_pre_write: got %h want %h", dr_a[31:0], exp_a(5'd5));
    end
    rst_n = 1'b0;
    model_reset();
    #2;
    total++;
    if (dr_a[31:0] !== 32'd0) begin
      bad++;
      $display("FAIL reset_async_dr0: got %h want %h", dr_a[31:0], 32'd0);
    end
    total++;
    if (busy_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_async_busy: got %b want 0", busy_a);
    end
    rst_n = 1'b1;
    tick();
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    tick();
    tick();
    total++;
    if (busy_a !== (left_a > 0)) begin
      bad++;
      $display("FAIL reset_clear_started: got %b want %b", busy_a, left_a > 0);
    end
    rst_n = 1'b0;
    model_reset();
    #2;
    total++;
    if (busy_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_clear_busy: got %b want 0", busy_a);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (busy_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_after_release_busy: got %b want 0", busy_a);
    end
  endtask

  task automatic test_rdw();
    en_a = 1'b1; aw_a = 5'd7; dw_a = 32'h1234_5678; ar_a[4:0] = 5'd7;
    #1;
    total++;
    if (dr_a[31:0] !== exp_a(5'd7)) begin
      bad++;
      $display("FAIL rdw_same_cycle: got %h want %h", dr_a[31:0], exp_a(5'd7));
    end
    tick();
    en_a = 1'b0;
    #1;
    total++;
    if (dr_a[31:0] !== 32'h1234_5678) begin
      bad++;
      $display("FAIL rdw_next_cycle: got %h want %h", dr_a[31:0], 32'h1234_5678);
    end
  endtask

  task automatic test_zero_r0();
    en_a = 1'b1; aw_a = 5'd0; dw_a = 32'hFFFF_FFFF; ar_a[4:0] = 5'd0;
    en_b = 1'b1; aw_b = 4'd0; dw_b = 32'hFFFF_FFFF; ar_b[3:0] = 4'd0;
    #1;
    total++;
    if (dr_a[31:0] !== 32'd0) begin
      bad++;
      $display("FAIL r0_same_cycle: got %h want %h", dr_a[31:0], 32'd0);
    end
    tick();
    en_a = 1'b0; en_b = 1'b0;
    #1;
    total++;
    if (dr_a[31:0] !== 32'd0) begin
      bad++;
      $display("FAIL r0_hardwired: got %h want %h", dr_a[31:0], 32'd0);
    end
    total++;
    if (dr_b[31:0] !== exp_b(4'd0)) begin
      bad++;
      $display("FAIL r0_ordinary: got %h want %h", dr_b[31:0], exp_b(4'd0));
    end
  endtask

  task automatic test_clear();
    int n;
    for (int i = 0; i < 32; i++) begin
      en_a = 1'b1; aw_a = 5'(i); dw_a = 32'(i + 1);
      tick();
    end
    en_a = 1'b0; clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 40) begin
      n++;
      if (n == 10) begin
        ar_a[4:0] = 5'd3; ar_a[9:5] = 5'd20;
        #1;
        total++;
        if (dr_a[31:0] !== exp_a(5'd3)) begin
          bad++;
          $display("FAIL clear_mid_cleared: got %h want %h", dr_a[31:0], exp_a(5'd3));
        end
        total++;
        if (dr_a[63:32] !== exp_a(5'd20)) begin
          bad++;
          $display("FAIL clear_mid_pending: got %h want %h", dr_a[63:32], exp_a(5'd20));
        end
      end
      tick();
    end
    total++;
    if (n != 32) begin
      bad++;
      $display("FAIL clear_busy_cycles: got %0d want %0d", n, 32);
    end
    for (int i = 0; i < 32; i++) begin
      ar_a[4:0] = 5'(i);
      #1;
      total++;
      if (dr_a[31:0] !== exp_a(5'(i))) begin
        bad++;
        $display("FAIL clear_final_r%0d: got %h want %h", i, dr_a[31:0], exp_a(5'(i)));
      end
    end
  endtask

  task automatic test_clear_collision();
    int n;
    en_a = 1'b1; aw_a = 5'd9; dw_a = 32'd77;
    tick();
    aw_a = 5'd4; dw_a = 32'h4444; clr_a = 1'b1;
    tick();
    en_a = 1'b0; clr_a = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 40) begin
      n++;
      if (n == 5) begin
        en_a = 1'b1; aw_a = 5'd9; dw_a = 32'hA5A5; clr_a = 1'b1;
      end else begin
        en_a = 1'b0; clr_a = 1'b0;
      end
      tick();
    end
    en_a = 1'b0; clr_a = 1'b0;
    total++;
    if (n != 32) begin
      bad++;
      $display("FAIL collide_busy_cycles: got %0d want %0d", n, 32);
    end
    ar_a[4:0] = 5'd9; ar_a[9:5] = 5'd4;
    #1;
    total++;
    if (dr_a[31:0] !== exp_a(5'd9)) begin
      bad++;
      $display("FAIL collide_dropped_write: got %h want %h", dr_a[31:0], exp_a(5'd9));
    end
    total++;
    if (dr_a[63:32] !== exp_a(5'd4)) begin
      bad++;
      $display("FAIL collide_write_then_clear: got %h want %h", dr_a[63:32], exp_a(5'd4));
    end
    tick();
    total++;
    if (busy_a !== 1'b0) begin
      bad++;
      $display("FAIL collide_no_restart: got %b want 0", busy_a);
    end
  endtask

  task automatic test_multi_port();
    logic [3:0]  addr [4];
    logic [31:0] got;
    for (int i = 0; i < 16; i++) begin
      en_b = 1'b1; aw_b = 4'(i); dw_b = $urandom;
      tick();
    end
    en_b = 1'b0;
    addr[0] = 4'd1; addr[1] = 4'd1; addr[2] = 4'd15; addr[3] = 4'd0;
    for (int k = 0; k < 4; k++) ar_b[k*4 +: 4] = addr[k];
    #1;
    for (int k = 0; k < 4; k++) begin
      got = dr_b[k*32 +: 32];
      total++;
      if (got !== exp_b(addr[k])) begin
        bad++;
        $display("FAIL multi_port%0d: got %h want %h", k, got, exp_b(addr[k]));
      end
    end
    for (int it = 0; it < 40; it++) begin
      en_b = 1'($urandom_range(0, 1)); aw_b = 4'($urandom); dw_b = $urandom;
      for (int k = 0; k < 4; k++) begin
        addr[k] = 4'($urandom);
        ar_b[k*4 +: 4] = addr[k];
      end
      #1;
      for (int k = 0; k < 4; k++) begin
        got = dr_b[k*32 +: 32];
        total++;
        if (got !== exp_b(addr[k])) begin
          bad++;
          $display("FAIL multi_rand%0d_p%0d: got %h want %h", it, k, got, exp_b(addr[k]));
        end
      end
      tick();
    end
    en_b = 1'b0;
  endtask

  task automatic test_random();
    logic [4:0]  addr [2];
    logic [31:0] got;
    for (int it = 0; it < 300; it++) begin
      en_a  = 1'($urandom_range(0, 1));
      aw_a  = 5'($urandom);
      dw_a  = $urandom;
      clr_a = ($urandom_range(0, 59) == 0);
      for (int k = 0; k < 2; k++) begin
        addr[k] = 5'($urandom);
        ar_a[k*5 +: 5] = addr[k];
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        got = dr_a[k*32 +: 32];
        total++;
        if (got !== exp_a(addr[k])) begin
          bad++;
          $display("FAIL rand%0d_p%0d: got %h want %h", it, k, got, exp_a(addr[k]));
        end
      end
      tick();
      total++;
      if (busy_a !== (left_a > 0)) begin
        bad++;
        $display("FAIL rand%0d_busy: got %b want %b", it, busy_a, left_a > 0);
      end
    end
    en_a = 1'b0; clr_a = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rdw();
    test_zero_r0();
    test_clear();
    test_clear_collision();
    test_multi_port();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
